// File: rtl/instr_mem_rd_arbiter.sv
// ---------------------------------------------------------------------------
// instr_mem_rd_arbiter
//
// Shares one AXI4 read master port between N_REQ instruction-cache
// controllers. One requester at a time is granted in round-robin order. Its
// AR channel is forwarded downstream, and the R burst is steered back to it
// until the last beat. Only then does arbitration run again.
//
// Ports:
//   i_clk, i_areset_n        clock, asynchronous active-low reset
//   i_arvalid/araddr/arlen/  per-requester AR channel (packed [N_REQ][...])
//   arsize/arburst
//   o_arready                per-requester AR ready (at most one bit set)
//   o_rvalid, i_rready       per-requester R handshake (granted bit only)
//   o_rdata/o_rresp/o_rlast  broadcast R payload
//   o_m_ar*, i_m_arready     downstream AR channel
//   i_m_r*, o_m_rready       downstream R channel
//   o_grant                  registered one-hot grant, zero when idle
//   o_len_err                one-cycle pulse when rlast disagrees with arlen
// ---------------------------------------------------------------------------
module instr_mem_rd_arbiter #(
    parameter int N_REQ     = 2,
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32
) (
    input  logic                                i_clk,
    input  logic                                i_areset_n,
    input  logic [N_REQ-1:0]                    i_arvalid,
    input  logic [N_REQ-1:0][ADDR_SIZE-1:0]     i_araddr,
    input  logic [N_REQ-1:0][7:0]               i_arlen,
    input  logic [N_REQ-1:0][2:0]               i_arsize,
    input  logic [N_REQ-1:0][1:0]               i_arburst,
    output logic [N_REQ-1:0]                    o_arready,
    output logic [N_REQ-1:0]                    o_rvalid,
    output logic [DATA_SIZE-1:0]                o_rdata,
    output logic [1:0]                          o_rresp,
    output logic                                o_rlast,
    input  logic [N_REQ-1:0]                    i_rready,
    output logic                                o_m_arvalid,
    output logic [ADDR_SIZE-1:0]                o_m_araddr,
    output logic [7:0]                          o_m_arlen,
    output logic [2:0]                          o_m_arsize,
    output logic [1:0]                          o_m_arburst,
    input  logic                                i_m_arready,
    input  logic                                i_m_rvalid,
    input  logic [DATA_SIZE-1:0]                i_m_rdata,
    input  logic [1:0]                          i_m_rresp,
    input  logic                                i_m_rlast,
    output logic                                o_m_rready,
    output logic [N_REQ-1:0]                    o_grant,
    output logic                                o_len_err
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   gnt_idx_r;
    logic [N_REQ-1:0]   gnt_r;
    logic [IDX_W-1:0]   last_r;
    logic [7:0]         len_r;
    logic [7:0]         beat_cnt_r;
    logic               len_err_r;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [N_REQ-1:0]   pick_oh_s;

    // First requesting index searching upward from last+1, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [IDX_W-1:0] last,
        input logic [N_REQ-1:0] req
    );
        logic [IDX_W-1:0] sel;
        logic             found;
        int               cand;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last) + k) % N_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = IDX_W'(cand);
            end
        end
        return sel;
    endfunction

    // Round-robin winner and its one-hot form, consumed only in IDLE.
    always_comb begin
        pick_idx_s = rr_pick(last_r, i_arvalid);
        pick_oh_s  = '0;
        pick_oh_s[pick_idx_s] = 1'b1;
    end

    // Handshake steering: only the granted requester sees ready/valid, and
    // only in the state owning that channel.
    always_comb begin
        o_arready   = '0;
        o_rvalid    = '0;
        o_m_arvalid = 1'b0;
        o_m_rready  = 1'b0;
        case (state_r)
            ST_ADDR: begin
                o_m_arvalid          = i_arvalid[gnt_idx_r];
                o_arready[gnt_idx_r] = i_m_arready;
            end
            ST_DATA: begin
                o_rvalid[gnt_idx_r]  = i_m_rvalid;
                o_m_rready           = i_rready[gnt_idx_r];
            end
            default: begin
                o_m_arvalid = 1'b0;
            end
        endcase
    end

    // AR payload of the granted requester; meaningful only while in ADDR.
    assign o_m_araddr  = i_araddr[gnt_idx_r];
    assign o_m_arlen   = i_arlen[gnt_idx_r];
    assign o_m_arsize  = i_arsize[gnt_idx_r];
    assign o_m_arburst = i_arburst[gnt_idx_r];

    // R payload is broadcast; requesters qualify it with their own rvalid.
    assign o_rdata = i_m_rdata;
    assign o_rresp = i_m_rresp;
    assign o_rlast = i_m_rlast;

    assign o_grant   = gnt_r;
    assign o_len_err = len_err_r;

    // Arbitration FSM with grant, rotation pointer and burst-length tracking.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_r    <= ST_IDLE;
            gnt_idx_r  <= '0;
            gnt_r      <= '0;
            last_r     <= IDX_W'(N_REQ - 1);
            len_r      <= 8'd0;
            beat_cnt_r <= 8'd0;
            len_err_r  <= 1'b0;
        end else begin
            len_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (|i_arvalid) begin
                        gnt_idx_r <= pick_idx_s;
                        gnt_r     <= pick_oh_s;
                        state_r   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (i_arvalid[gnt_idx_r] && i_m_arready) begin
                        len_r      <= i_arlen[gnt_idx_r];
                        beat_cnt_r <= 8'd0;
                        state_r    <= ST_DATA;
                    end else if (!i_arvalid[gnt_idx_r]) begin
                        // Requester withdrew: drop the grant, keep rotation.
                        gnt_r   <= '0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (i_m_rvalid && i_rready[gnt_idx_r]) begin
                        if (beat_cnt_r != 8'hFF) begin
                            beat_cnt_r <= beat_cnt_r + 8'd1;
                        end
                        if (i_m_rlast) begin
                            // Pre-increment count equals arlen on a well-formed burst.
                            len_err_r <= (beat_cnt_r != len_r);
                            last_r    <= gnt_idx_r;
                            gnt_r     <= '0;
                            state_r   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    gnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_rd_arbiter.sv
module tb_instr_mem_rd_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                   i_clk = 1'b0;
    logic                   i_areset_n;
    logic [N-1:0]           arvalid;
    logic [N-1:0][AW-1:0]   araddr;
    logic [N-1:0][7:0]      arlen;
    logic [N-1:0][2:0]      arsize;
    logic [N-1:0][1:0]      arburst;
    logic [N-1:0]           o_arready;
    logic [N-1:0]           o_rvalid;
    logic [DW-1:0]          o_rdata;
    logic [1:0]             o_rresp;
    logic                   o_rlast;
    logic [N-1:0]           rready;
    logic                   o_m_arvalid;
    logic [AW-1:0]          o_m_araddr;
    logic [7:0]             o_m_arlen;
    logic [2:0]             o_m_arsize;
    logic [1:0]             o_m_arburst;
    logic                   i_m_arready;
    logic                   i_m_rvalid;
    logic [DW-1:0]          i_m_rdata;
    logic [1:0]             i_m_rresp;
    logic                   i_m_rlast;
    logic                   o_m_rready;
    logic [N-1:0]           o_grant;
    logic                   o_len_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_last   = N - 1;

    // Results of the most recent serve() call.
    logic [N-1:0]  r_gnt, r_arready, r_gnt_next;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_len;
    logic [2:0]    r_size;
    logic [1:0]    r_burst;
    int            r_ar_wait, r_rx, r_hs_bad, r_data_bad, r_bp_zero;
    logic          r_err1, r_err2, r_idle1;
    bit            r_timeout;

    instr_mem_rd_arbiter #(.N_REQ(N), .ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .i_clk(i_clk), .i_areset_n(i_areset_n),
        .i_arvalid(arvalid), .i_araddr(araddr), .i_arlen(arlen),
        .i_arsize(arsize), .i_arburst(arburst), .o_arready(o_arready),
        .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_rresp(o_rresp),
        .o_rlast(o_rlast), .i_rready(rready),
        .o_m_arvalid(o_m_arvalid), .o_m_araddr(o_m_araddr),
        .o_m_arlen(o_m_arlen), .o_m_arsize(o_m_arsize),
        .o_m_arburst(o_m_arburst), .i_m_arready(i_m_arready),
        .i_m_rvalid(i_m_rvalid), .i_m_rdata(i_m_rdata),
        .i_m_rresp(i_m_rresp), .i_m_rlast(i_m_rlast),
        .o_m_rready(o_m_rready), .o_grant(o_grant), .o_len_err(o_len_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference rule: first requester searching upward from last+1, wrapping.
    function automatic int pick(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int idx);
        logic [N-1:0] v;
        v = '0;
        if (idx >= 0 && idx < N) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge i_clk); #2; end
    endtask

    // Plays memory for one transaction and records what the DUT did.
    task automatic serve(input int nb, input int bp_at, input int bp_len,
                         input bit hold, input bit rand_bp);
        int cyc, dcyc, sent, g;
        logic [DW-1:0] cur;
        bit seen;
        r_timeout = 0; r_hs_bad = 0; r_data_bad = 0; r_rx = 0; r_bp_zero = 0;
        r_gnt = '0; r_ar_wait = -1; g = 0; seen = 0; cyc = 0;
        while (!seen && cyc < 40) begin
            @(posedge i_clk); #2;
            if (o_m_arvalid === 1'b1) begin
                seen = 1;
                i_m_arready = 1'b1;
                #1;
                r_ar_wait = cyc; r_gnt = o_grant; r_arready = o_arready;
                r_addr = o_m_araddr; r_len = o_m_arlen;
                r_size = o_m_arsize; r_burst = o_m_arburst;
            end
            cyc++;
        end
        if (!seen) begin
            r_timeout = 1;
            return;
        end
        for (int i = N - 1; i >= 0; i--) if (r_gnt[i]) g = i;
        @(posedge i_clk); #1;
        i_m_arready = 1'b0;
        if (!hold) arvalid[g] = 1'b0;
        cur = $urandom; sent = 0; dcyc = 0;
        while (sent < nb && dcyc < 200) begin
            i_m_rvalid = 1'b1; i_m_rdata = cur; i_m_rresp = cur[1:0];
            i_m_rlast = (sent == nb - 1);
            rready = '1;
            if (rand_bp) rready[g] = 1'($urandom_range(0, 1));
            else if (dcyc >= bp_at && dcyc < bp_at + bp_len) rready[g] = 1'b0;
            #1;
            if (o_m_rready !== rready[g]) r_hs_bad++;
            if (rready[g] == 1'b0 && o_m_rready === 1'b0) r_bp_zero++;
            if ((o_rvalid & ~oh(g)) !== '0 || o_rvalid[g] !== 1'b1) r_hs_bad++;
            if (o_arready !== '0 || o_m_arvalid !== 1'b0) r_hs_bad++;
            if (o_m_rready === 1'b1) begin
                if (o_rdata !== cur || o_rresp !== cur[1:0] || o_rlast !== i_m_rlast)
                    r_data_bad++;
                r_rx++; sent++; cur = $urandom;
            end
            dcyc++;
            @(posedge i_clk); #1;
        end
        if (sent < nb) r_timeout = 1;
        i_m_rvalid = 1'b0; i_m_rlast = 1'b0; rready = '1;
        #1;
        r_err1 = o_len_err; r_idle1 = (o_grant == '0);
        @(posedge i_clk); #2;
        r_err2 = o_len_err; r_gnt_next = o_grant;
    endtask

    task automatic test_reset();
        arvalid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        rready = '1; i_m_arready = 1'b0; i_m_rvalid = 1'b0; i_m_rdata = '0;
        i_m_rresp = 2'd0; i_m_rlast = 1'b0;
        i_areset_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #2;
        tests_run++; if (o_grant !== '0) begin tests_failed++; $display("FAIL reset_grant: got %b expected 0", o_grant); end
        tests_run++; if ({o_arready, o_rvalid, o_m_arvalid, o_m_rready, o_len_err} !== '0) begin tests_failed++; $display("FAIL reset_handshakes: got %b expected 0", {o_arready, o_rvalid, o_m_arvalid, o_m_rready, o_len_err}); end
        i_areset_n = 1'b1;
        idle(3);
        tests_run++; if (o_grant !== '0 || o_m_arvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_idle: grant %b arvalid %b expected 0", o_grant, o_m_arvalid); end
        model_last = N - 1;
    endtask

    task automatic test_simultaneous();
        int exp;
        araddr[0] = 32'h0000_1000; arlen[0] = 8'd1;
        araddr[1] = 32'h0000_2000; arlen[1] = 8'd2;
        arvalid = 3'b011;
        for (int i = 0; i < 4; i++) begin
            exp = i % 2;
            serve(int'(arlen[exp]) + 1, 0, 0, 1'b1, 1'b0);
            tests_run++; if (r_gnt !== oh(exp) || r_timeout) begin tests_failed++; $display("FAIL simul_grant[%0d]: got %b expected %b", i, r_gnt, oh(exp)); end
            tests_run++; if (r_addr !== araddr[exp] || r_err1 !== 1'b0) begin tests_failed++; $display("FAIL simul_addr[%0d]: got %h err %b expected %h err 0", i, r_addr, r_err1, araddr[exp]); end
            if (i < 3) begin
                tests_run++; if (r_gnt_next !== oh((i + 1) % 2)) begin tests_failed++; $display("FAIL simul_next_grant[%0d]: got %b expected %b", i, r_gnt_next, oh((i + 1) % 2)); end
            end
            model_last = exp;
        end
        arvalid = '0;
        idle(2);
    endtask

    task automatic test_single_burst();
        arvalid = '0;
        araddr[0] = 32'h0000_0100; arlen[0] = 8'd3; arsize[0] = 3'd2; arburst[0] = 2'd1;
        arvalid[0] = 1'b1;
        serve(4, 0, 0, 1'b0, 1'b0);
        tests_run++; if (r_gnt !== 3'b001 || r_arready !== 3'b001) begin tests_failed++; $display("FAIL single_grant: grant %b arready %b expected 001", r_gnt, r_arready); end
        tests_run++; if (r_ar_wait !== 0) begin tests_failed++; $display("FAIL single_latency: got %0d expected 0", r_ar_wait); end
        tests_run++; if (r_addr !== 32'h100 || r_len !== 8'd3 || r_size !== 3'd2 || r_burst !== 2'd1) begin tests_failed++; $display("FAIL single_ar: addr %h len %0d size %0d burst %0d expected 100 3 2 1", r_addr, r_len, r_size, r_burst); end
        tests_run++; if (r_rx !== 4 || r_data_bad !== 0 || r_hs_bad !== 0 || r_timeout) begin tests_failed++; $display("FAIL single_beats: got %0d data_bad %0d hs_bad %0d expected 4 0 0", r_rx, r_data_bad, r_hs_bad); end
        tests_run++; if (r_err1 !== 1'b0 || r_idle1 !== 1'b1) begin tests_failed++; $display("FAIL single_end: err %b idle %b expected 0 1", r_err1, r_idle1); end
        model_last = 0;
    endtask

    task automatic test_backpressure();
        arvalid = '0; araddr[0] = 32'h0000_0400; arlen[0] = 8'd3; arvalid[0] = 1'b1;
        serve(4, 1, 3, 1'b0, 1'b0);
        tests_run++; if (r_gnt !== oh(pick(model_last, 3'b001))) begin tests_failed++; $display("FAIL bp_grant: got %b expected 001", r_gnt); end
        tests_run++; if (r_bp_zero !== 3 || r_hs_bad !== 0) begin tests_failed++; $display("FAIL bp_rready: zero cycles %0d hs_bad %0d expected 3 0", r_bp_zero, r_hs_bad); end
        tests_run++; if (r_rx !== 4 || r_data_bad !== 0 || r_err1 !== 1'b0 || r_timeout) begin tests_failed++; $display("FAIL bp_beats: got %0d data_bad %0d err %b expected 4 0 0", r_rx, r_data_bad, r_err1); end
        model_last = 0;
    endtask

    task automatic test_len_err();
        arvalid = '0; araddr[1] = 32'h0000_0800; arlen[1] = 8'd3; arvalid[1] = 1'b1;
        serve(2, 0, 0, 1'b0, 1'b0);
        tests_run++; if (r_gnt !== 3'b010 || r_rx !== 2 || r_timeout) begin tests_failed++; $display("FAIL lenerr_burst: grant %b beats %0d expected 010 2", r_gnt, r_rx); end
        tests_run++; if (r_err1 !== 1'b1 || r_err2 !== 1'b0) begin tests_failed++; $display("FAIL lenerr_pulse: got %b%b expected 10", r_err1, r_err2); end
        tests_run++; if (r_idle1 !== 1'b1) begin tests_failed++; $display("FAIL lenerr_idle: got %b expected 1", r_idle1); end
        model_last = 1;
    endtask

    task automatic test_abort();
        int cyc, exp;
        bit seen;
        idle(2);
        i_m_arready = 1'b0; arvalid = '0;
        araddr[2] = 32'h0000_3000; arlen[2] = 8'd1; arvalid[2] = 1'b1;
        seen = 0; cyc = 0;
        while (!seen && cyc < 20) begin
            @(posedge i_clk); #2;
            if (o_m_arvalid === 1'b1) seen = 1;
            cyc++;
        end
        tests_run++; if (!seen || o_grant !== oh(pick(model_last, 3'b100))) begin tests_failed++; $display("FAIL abort_grant: seen %b grant %b expected 1 100", seen, o_grant); end
        arvalid[2] = 1'b0;
        #1;
        tests_run++; if (o_m_arvalid !== 1'b0 || o_arready !== '0) begin tests_failed++; $display("FAIL abort_drop: arvalid %b arready %b expected 0", o_m_arvalid, o_arready); end
        @(posedge i_clk); #2;
        i_m_arready = 1'b1;
        #1;
        tests_run++; if (o_grant !== '0 || o_m_arvalid !== 1'b0) begin tests_failed++; $display("FAIL abort_idle: grant %b arvalid %b expected 0", o_grant, o_m_arvalid); end
        i_m_arready = 1'b0;
        araddr[0] = 32'h0000_5000; arlen[0] = 8'd0; araddr[2] = 32'h0000_6000; arlen[2] = 8'd0;
        arvalid = 3'b101;
        exp = pick(model_last, 3'b101);
        serve(1, 0, 0, 1'b0, 1'b0);
        tests_run++; if (r_gnt !== oh(exp) || r_addr !== araddr[exp]) begin tests_failed++; $display("FAIL abort_rotation: grant %b addr %h expected %b %h", r_gnt, r_addr, oh(exp), araddr[exp]); end
        model_last = exp;
        exp = pick(model_last, 3'b001);
        serve(1, 0, 0, 1'b0, 1'b0);
        tests_run++; if (r_gnt !== oh(exp) || r_timeout) begin tests_failed++; $display("FAIL abort_follow: grant %b expected %b", r_gnt, oh(exp)); end
        model_last = exp;
        idle(2);
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        bit seen;
        arvalid = '0; araddr[1] = 32'h0000_7000; arlen[1] = 8'd3; arvalid[1] = 1'b1;
        seen = 0; cyc = 0;
        while (!seen && cyc < 20) begin
            @(posedge i_clk); #2;
            if (o_m_arvalid === 1'b1) begin seen = 1; i_m_arready = 1'b1; end
            cyc++;
        end
        @(posedge i_clk); #1;
        i_m_arready = 1'b0; arvalid[1] = 1'b0;
        i_m_rvalid = 1'b1; i_m_rdata = 32'hA5A5_0001; i_m_rlast = 1'b0; rready = '1;
        @(posedge i_clk); #1;
        i_m_rdata = 32'hA5A5_0002;
        #1;
        tests_run++; if (!seen || o_rvalid !== 3'b010) begin tests_failed++; $display("FAIL rst_mid_beat2: seen %b rvalid %b expected 1 010", seen, o_rvalid); end
        i_areset_n = 1'b0;
        #1;
        tests_run++; if ({o_grant, o_len_err, o_arready, o_rvalid, o_m_arvalid, o_m_rready} !== '0) begin tests_failed++; $display("FAIL rst_mid_outputs: got %b expected 0", {o_grant, o_len_err, o_arready, o_rvalid, o_m_arvalid, o_m_rready}); end
        i_m_rvalid = 1'b0;
        idle(2);
        i_areset_n = 1'b1;
        model_last = N - 1;
        idle(1);
        araddr[0] = 32'h0000_8000; arlen[0] = 8'd1; arvalid = 3'b011;
        serve(2, 0, 0, 1'b0, 1'b0);
        tests_run++; if (r_gnt !== oh(pick(model_last, 3'b011)) || r_gnt !== 3'b001) begin tests_failed++; $display("FAIL rst_mid_next: grant %b expected 001", r_gnt); end
        model_last = 0;
        arvalid = '0;
        idle(3);
    endtask

    task automatic test_random();
        logic [N-1:0] pending;
        int exp, nb;
        bit exp_err;
        for (int rnd = 0; rnd < 12; rnd++) begin
            pending = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                araddr[i] = $urandom; arlen[i] = 8'($urandom_range(0, 6));
                arsize[i] = 3'($urandom_range(0, 7)); arburst[i] = 2'($urandom_range(0, 3));
            end
            arvalid = pending;
            while (pending != '0) begin
                exp = pick(model_last, pending);
                nb = int'(arlen[exp]) + 1;
                if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, 8);
                exp_err = (nb != int'(arlen[exp]) + 1);
                serve(nb, 0, 0, 1'b0, 1'b1);
                tests_run++; if (r_gnt !== oh(exp) || r_timeout) begin tests_failed++; $display("FAIL rand_grant[%0d]: got %b expected %b", rnd, r_gnt, oh(exp)); end
                tests_run++; if (r_addr !== araddr[exp] || r_len !== arlen[exp] || r_size !== arsize[exp] || r_burst !== arburst[exp]) begin tests_failed++; $display("FAIL rand_ar[%0d]: got %h/%0d/%0d/%0d expected %h/%0d/%0d/%0d", rnd, r_addr, r_len, r_size, r_burst, araddr[exp], arlen[exp], arsize[exp], arburst[exp]); end
                tests_run++; if (r_rx !== nb || r_data_bad !== 0 || r_hs_bad !== 0) begin tests_failed++; $display("FAIL rand_beats[%0d]: got %0d data_bad %0d hs_bad %0d expected %0d 0 0", rnd, r_rx, r_data_bad, r_hs_bad, nb); end
                tests_run++; if (r_err1 !== exp_err || r_err2 !== 1'b0) begin tests_failed++; $display("FAIL rand_lenerr[%0d]: got %b%b expected %b0", rnd, r_err1, r_err2, exp_err); end
                pending[exp] = 1'b0;
                model_last = exp;
            end
            arvalid = '0;
            idle(2);
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single_burst();
        test_backpressure();
        test_len_err();
        test_abort();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_mem_rd_arbiter.md
# instr_mem_rd_arbiter

Round-robin arbiter that shares one AXI4 read master port to memory between `N_REQ` instruction-cache controllers, one per core. It grants one requester at a time and forwards that requester's AR channel downstream. It then steers the R-channel burst back to the same requester until the last beat, and only then arbitrates again. It sits between the per-core instruction cache controllers and the memory-side AXI interconnect.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (≥2)
- `ADDR_SIZE`, 32, AXI address width
- `DATA_SIZE`, 32, AXI read data width

Ports:
- `i_clk` in 1: system clock; all logic on rising edge
- `i_areset_n` in 1: one clock; reset is asynchronous and active-low
- `i_arvalid` in [N_REQ]: per-requester AR valid
- `i_araddr` in [N_REQ][ADDR_SIZE]: per-requester AR address
- `i_arlen` in [N_REQ][8]: per-requester burst length minus one
- `i_arsize` in [N_REQ][3], `i_arburst` in [N_REQ][2]: per-requester size and burst type
- `o_arready` out [N_REQ]: AR ready, at most one bit set
- `o_rvalid` out [N_REQ]: R valid, only the granted bit can be set
- `o_rdata` out DATA_SIZE, `o_rresp` out 2, `o_rlast` out 1: broadcast copies of the downstream R payload
- `i_rready` in [N_REQ]: per-requester R ready
- `o_m_arvalid`, `o_m_araddr`, `o_m_arlen`, `o_m_arsize`, `o_m_arburst` out: downstream AR channel
- `i_m_arready` in 1: downstream AR ready
- `i_m_rvalid`, `i_m_rdata`, `i_m_rresp`, `i_m_rlast` in: downstream R channel
- `o_m_rready` out 1: downstream R ready
- `o_grant` out [N_REQ]: one-hot registered grant; zero in IDLE
- `o_len_err` out 1: one-cycle pulse on burst length mismatch

## Operation
States:
- **IDLE**
  - If any `i_arvalid` is set, select the first set bit searching upward from `(last+1) mod N_REQ` and wrap around.
  - Register the winner in `gnt` (`o_grant` becomes one-hot) and go to ADDR.
  - With no request, stay in IDLE.
- **ADDR**
  - `o_m_ar*` = AR fields of requester `gnt`, driven combinationally; `o_m_arvalid = i_arvalid[gnt]`.
  - `o_arready[gnt] = i_m_arready`.
  - On handshake (`o_m_arvalid & i_m_arready`):
    - latch `len = i_arlen[gnt]`;
    - clear `beat_cnt` to 0;
    - go to DATA.
  - If `i_arvalid[gnt]` drops before the handshake, return to IDLE without issuing and without updating `last`.
- **DATA**
  - `o_rvalid[gnt] = i_m_rvalid`; `o_m_rready = i_rready[gnt]`.
  - The R payload is broadcast unchanged.
  - Each R handshake increments `beat_cnt` (8-bit; saturates at 255).
  - On the handshake with `i_m_rlast = 1`:
    - set `last = gnt`, clear `gnt`, go to IDLE;
    - pulse `o_len_err` if `beat_cnt != len` (the count before increment).
- Only one transaction is outstanding at a time. AR of other requesters is never accepted while a grant is held.
- Arbitration inputs are ignored outside IDLE. A new `i_arvalid` that arrives in ADDR or DATA waits.
- The rotation pointer `last` resets to `N_REQ-1`, so requester 0 wins the first arbitration.
- When not granted or not in the matching state, every `o_arready`, `o_rvalid`, `o_m_arvalid` and `o_m_rready` is 0.
- `o_m_ar*` payload is don't-care in IDLE and DATA. `o_rdata`/`o_rresp`/`o_rlast` are valid only when some `o_rvalid` is set.

## Timing
- Reset (asynchronous, any state, including mid-burst):
  - state = IDLE, `gnt = 0`, `last = N_REQ-1`, `beat_cnt = 0`, `len = 0`;
  - `o_grant = 0`, `o_len_err = 0`, all valid/ready outputs 0.
  - The downstream transaction in flight is abandoned; the interconnect is reset by the same net.
- Arbitration latency: request seen in IDLE at cycle t; `o_m_arvalid` asserted at t+1.
- AR pass-through is zero-cycle combinational. The earliest DATA entry is t+2 if `i_m_arready` is high at t+1.
- R path is zero-cycle combinational in both directions, so back-pressure from `i_rready` maps directly to `o_m_rready`.
- After the last beat at cycle u, the arbiter is in IDLE at u+1, and the next grant is visible at u+2. There is a minimum one idle cycle between bursts.
- If the last beat and a new request are both present at cycle u, the new request is evaluated at u+1 with the updated `last`.
- `o_len_err` is registered and asserts for exactly one cycle after the offending last beat.

## Test plan
- **Single requester, 4-beat burst:**
  - Stimulus: reset; req0 sends `araddr=0x100`, `arlen=3`; memory returns 4 beats with `rlast` on beat 4.
  - Response: `o_m_araddr=0x100`; `o_rvalid[0]` on 4 beats; `o_len_err=0`; IDLE after the last beat.
- **Simultaneous requests:**
  - Stimulus: req0 and req1 both request at the same cycle after reset.
  - Response: req0 is served first, then req1; with both held continuously, the grants alternate 0,1,0,1.
- **R back-pressure:**
  - Stimulus: granted requester drops `i_rready` for 3 cycles mid-burst.
  - Response: `o_m_rready=0` for those cycles; no beats are lost or duplicated; the count completes at 4.
- **Length error:**
  - Stimulus: `arlen=3`, memory asserts `rlast` on beat 2.
  - Response: `o_len_err` pulses once; return to IDLE.
- **Abort and reset mid-burst:**
  - Stimulus: `i_arvalid[gnt]` drops in ADDR; separately, reset is asserted on beat 2 of 4.
  - Response: abort returns to IDLE with no downstream `arvalid` accepted. Reset forces all outputs to 0 immediately, and the next grant goes to req0.
